uart_word_packer: RTL

//  Consumes bytes from the UART receiver (its result/done outputs) and packs them little-endian

---
 rtl/uart_word_packer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_word_packer.sv
// ---------------------------------------------------------------------------
// uart_word_packer
//
// Packs bytes from a UART receiver into WORD_WIDTH-bit words, little-endian
// (first byte in the lowest lane). Completed words are buffered in a small
// first-word-fall-through FIFO and presented on a valid/ready master port.
// The UART side can never be stalled. A completed word that finds the FIFO
// full, with no pop in the same cycle, is dropped and the sticky overflow
// flag is set.
//
// Optional feature (macro PACKER_TIMEOUT_FLUSH_EN):
//   When defined, a partial word is flushed after TIMEOUT_CYCLES idle cycles.
//   Its unfilled lanes read as zero, and m_tkeep marks only the filled lanes.
//   When undefined, no idle counter is built and partial words wait
//   indefinitely. Every presented word then carries an all-ones m_tkeep.
//
// Ports:
//   clk        in   1           clock
//   rst_n      in   1           asynchronous active-low reset
//   byte_in    in   DATA_WIDTH  received byte (receiver result)
//   byte_valid in   1           byte_in is taken in every cycle this is high
//   m_tdata    out  WORD_WIDTH  word at the FIFO head
//   m_tkeep    out  LANES       lane-valid mask of the head word (0 when idle)
//   m_tvalid   out  1           FIFO not empty
//   m_tready   in   1           downstream ready
//   overflow   out  1           sticky flag: a completed word was dropped
//
// Handshake: a word transfers on every rising clk edge where m_tvalid and
// m_tready are both high. While m_tvalid is high and m_tready is low,
// m_tdata and m_tkeep hold their values. m_tvalid only falls after a
// transfer. m_tvalid does not depend on m_tready.
// ---------------------------------------------------------------------------
module uart_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  localparam int LANES         = WORD_WIDTH / DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic [WORD_WIDTH-1:0] m_tdata,
  output logic [LANES-1:0]      m_tkeep,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  overflow
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Word assembly
  // -------------------------------------------------------------------------
  logic [LANE_W-1:0]     lane;
  logic [WORD_WIDTH-1:0] asm_word;
  logic [WORD_WIDTH-1:0] word_with_byte;
  logic                  last_byte;
  logic                  flush;
  logic                  push_req;
  logic [WORD_WIDTH-1:0] push_data;
  logic [LANES-1:0]      push_keep;

  // The incoming byte merged into the word under assembly. On the last lane
  // this is the completed word, pushed in the same cycle the byte arrives.
  always_comb begin
    word_with_byte = asm_word;
    word_with_byte[int'(lane) * DATA_WIDTH +: DATA_WIDTH] = byte_in;
    last_byte = byte_valid && (lane == LANE_LAST);
  end

`ifdef PACKER_TIMEOUT_FLUSH_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0]  idle_cnt;
  logic [LANES-1:0] partial_keep;

  // The flush fires on the cycle that would bring the idle count to
  // TIMEOUT_CYCLES. A byte in that cycle takes priority, and no flush occurs.
  assign flush = (lane != '0) && !byte_valid && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (byte_valid || (lane == '0) || flush) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Lanes below the current lane index hold bytes.
  always_comb begin
    partial_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      partial_keep[i] = (i < int'(lane));
    end
  end

  assign push_keep = last_byte ? {LANES{1'b1}} : partial_keep;
`else
  assign flush     = 1'b0;
  assign push_keep = {LANES{1'b1}};

  // TIMEOUT_CYCLES only matters with the flush feature. This empty block
  // keeps the parameter referenced in this build.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  assign push_req  = last_byte || flush;
  assign push_data = last_byte ? word_with_byte : asm_word;

  // The assembly register clears after each push. Unfilled lanes of a
  // flushed word therefore read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      asm_word <= '0;
    end else if (byte_valid) begin
      if (last_byte) begin
        lane     <= '0;
        asm_word <= '0;
      end else begin
        lane     <= lane + 1'b1;
        asm_word <= word_with_byte;
      end
    end else if (flush) begin
      lane     <= '0;
      asm_word <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Word FIFO (first-word-fall-through)
  // -------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic [LANES-1:0]      head_keep;

  assign full     = (count == CNT_FULL);
  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid && m_tready;
  // When the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

`ifdef PACKER_TIMEOUT_FLUSH_EN
  logic [LANES-1:0] keep_mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        keep_mem[i] <= '0;
      end
    end else if (push) begin
      keep_mem[wr_ptr] <= push_keep;
    end
  end

  assign head_keep = keep_mem[rd_ptr];
`else
  assign head_keep = push_keep;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  assign m_tdata = mem[rd_ptr];
  // The keep mask is zero whenever no word is presented. This also makes
  // it read zero out of reset.
  assign m_tkeep = m_tvalid ? head_keep : '0;

endmodule
